// File: rtl/microwave_controller_if.sv
// Keypad, button, door and timer-stage signals shared between the microwave controller and its environment.
// The controller takes the slave side; the environment (panel plus timer stage) takes the master side.
interface microwave_controller_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       start;
   logic       stop;
   logic       door_closed;
   logic       timer_done;
   logic [3:0] timer_digit;
   logic       digit_strobe;
   logic       timer_loadn;
   logic       timer_enable;
   logic       timer_clearn;
   logic       mag_on;
   logic [2:0] state_out;

   modport master (
      output key_valid, key_code, start, stop, door_closed, timer_done,
      input  timer_digit, digit_strobe, timer_loadn, timer_enable, timer_clearn,
             mag_on, state_out
   );

   modport slave (
      input  key_valid, key_code, start, stop, door_closed, timer_done,
      output timer_digit, digit_strobe, timer_loadn, timer_enable, timer_clearn,
             mag_on, state_out
   );
endinterface

// File: rtl/microwave_controller.sv
// Microwave control FSM: keypad digit entry, cook/pause/done sequencing, and door interlock.
// Defining BEEP_EN adds a beep output that stays high for BEEP_CYCLES cycles on entry to DONE.
module microwave_controller #(
   parameter int BEEP_CYCLES = 8,
   parameter int MAX_DIGITS  = 3
) (
   input logic CLK,
   input logic clear,
   microwave_controller_if.slave bus
`ifdef BEEP_EN
   ,
   output logic beep
`endif
);
   localparam int CW = $clog2(MAX_DIGITS + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      COOK  = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t        state, nxt;
   logic          start_q, stop_q, start_rise, stop_rise;
   logic          is_digit, key_ok, key_acc, to_idle;
   logic [CW-1:0] digit_count;
   logic [3:0]    digit_q;
   logic          strobe_q, clearn_q;

   assign start_rise = bus.start & ~start_q;
   assign stop_rise  = bus.stop & ~stop_q;
   assign is_digit   = bus.key_valid && (bus.key_code <= 4'd9);
   assign key_ok     = is_digit && ((state == IDLE) || (state == ENTRY)) &&
                       (digit_count < CW'(MAX_DIGITS));

   // Priority is timer_done > stop > start > key; a key only counts when nothing else moves ENTRY.
   always_comb begin
      nxt     = state;
      key_acc = 1'b0;
      case (state)
         IDLE: begin
            if (key_ok) begin
               nxt     = ENTRY;
               key_acc = 1'b1;
            end
         end
         ENTRY: begin
            if (stop_rise)                          nxt = IDLE;
            else if (start_rise && bus.door_closed) nxt = COOK;
            else                                    key_acc = key_ok;
         end
         COOK: begin
            if (bus.timer_done)                      nxt = DONE;
            else if (stop_rise || !bus.door_closed)  nxt = PAUSE;
         end
         PAUSE: begin
            if (stop_rise)                          nxt = IDLE;
            else if (start_rise && bus.door_closed) nxt = COOK;
         end
         DONE: begin
            if (stop_rise || is_digit || !bus.door_closed) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   assign to_idle = (state != IDLE) && (nxt == IDLE);

   always_ff @(posedge CLK) begin
      if (clear) begin
         state       <= IDLE;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         digit_count <= '0;
         digit_q     <= 4'd0;
         strobe_q    <= 1'b0;
         clearn_q    <= 1'b0;
      end else begin
         state    <= nxt;
         start_q  <= bus.start;
         stop_q   <= bus.stop;
         strobe_q <= key_acc;
         clearn_q <= ~to_idle;
         if (key_acc) digit_q <= bus.key_code;
         // key_ok already bounds the count, so it saturates at MAX_DIGITS.
         if (to_idle)      digit_count <= '0;
         else if (key_acc) digit_count <= digit_count + CW'(1);
      end
   end

   assign bus.timer_digit  = digit_q;
   assign bus.digit_strobe = strobe_q;
   assign bus.timer_clearn = clearn_q;
   assign bus.timer_loadn  = !((state == IDLE) || (state == ENTRY));
   assign bus.timer_enable = (state == COOK);
   assign bus.mag_on       = (state == COOK);
   assign bus.state_out    = state;

`ifdef BEEP_EN
   localparam int BW = $clog2(BEEP_CYCLES + 1);
   logic [BW-1:0] beep_cnt;

   always_ff @(posedge CLK) begin
      if (clear)                                beep_cnt <= '0;
      else if ((nxt == DONE) && (state != DONE)) beep_cnt <= BW'(BEEP_CYCLES);
      else if (nxt != DONE)                     beep_cnt <= '0;
      else if (beep_cnt != '0)                  beep_cnt <= beep_cnt - BW'(1);
   end

   assign beep = (state == DONE) && (beep_cnt != '0);
`endif
endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller: digit entry, interlock, event priority, held buttons, clear.
module tb_microwave_controller;
   logic clk = 1'b0;
   logic clear;
   int   checks = 0;
   int   errors = 0;

   microwave_controller_if bus ();

`ifdef BEEP_EN
   logic beep;
   microwave_controller dut (.CLK(clk), .clear(clear), .bus(bus.slave), .beep(beep));
`else
   microwave_controller dut (.CLK(clk), .clear(clear), .bus(bus.slave));
`endif

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic key(input logic [3:0] code);
      bus.key_valid = 1'b1;
      bus.key_code  = code;
      tick();
      bus.key_valid = 1'b0;
   endtask

   initial begin
      int cook_entries;
      int prev_state;
      int beeps;

      bus.key_valid   = 1'b0;
      bus.key_code    = 4'd0;
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
      bus.door_closed = 1'b1;
      bus.timer_done  = 1'b0;

      // Reset state
      clear = 1'b1;
      tick();
      chk("rst_state", int'(bus.state_out), 0);
      chk("rst_clearn", int'(bus.timer_clearn), 0);
      chk("rst_strobe", int'(bus.digit_strobe), 0);
      chk("rst_digit", int'(bus.timer_digit), 0);
      chk("rst_loadn", int'(bus.timer_loadn), 0);
      chk("rst_enable", int'(bus.timer_enable), 0);
      chk("rst_mag", int'(bus.mag_on), 0);
      clear = 1'b0;
      tick();
      chk("rst_clearn_release", int'(bus.timer_clearn), 1);

      // start/stop in IDLE are ignored
      bus.start = 1'b1; bus.stop = 1'b1;
      tick();
      chk("idle_ignore_buttons", int'(bus.state_out), 0);
      bus.start = 1'b0; bus.stop = 1'b0;
      tick();

      // Keys 2,1,7 each strobe once with the digit
      key(4'd2);
      chk("k2_state", int'(bus.state_out), 1);
      chk("k2_strobe", int'(bus.digit_strobe), 1);
      chk("k2_digit", int'(bus.timer_digit), 2);
      tick();
      chk("k2_strobe_low", int'(bus.digit_strobe), 0);
      key(4'd1);
      chk("k1_strobe", int'(bus.digit_strobe), 1);
      chk("k1_digit", int'(bus.timer_digit), 1);
      tick();
      key(4'd7);
      chk("k7_strobe", int'(bus.digit_strobe), 1);
      chk("k7_digit", int'(bus.timer_digit), 7);
      tick();

      // Fourth digit and code 12 are ignored, count saturates at 3
      key(4'd4);
      chk("k4_no_strobe", int'(bus.digit_strobe), 0);
      chk("k4_digit_held", int'(bus.timer_digit), 7);
      key(4'd12);
      chk("k12_no_strobe", int'(bus.digit_strobe), 0);
      chk("digit_count_sat", int'(dut.digit_count), 3);

      // Held start: exactly one transition into COOK over 20 cycles
      bus.start = 1'b1;
      cook_entries = 0;
      prev_state = int'(bus.state_out);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (int'(bus.state_out) == 2 && prev_state != 2) cook_entries++;
         prev_state = int'(bus.state_out);
      end
      chk("held_start_one_entry", cook_entries, 1);
      chk("cook_state", int'(bus.state_out), 2);
      chk("cook_enable", int'(bus.timer_enable), 1);
      chk("cook_mag", int'(bus.mag_on), 1);
      chk("cook_loadn", int'(bus.timer_loadn), 1);
      bus.start = 1'b0;
      tick();

      // Door interlock: open door pauses, start with door open ignored
      bus.door_closed = 1'b0;
      tick();
      chk("door_pause", int'(bus.state_out), 3);
      chk("door_mag_off", int'(bus.mag_on), 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick(); tick(); tick();
      chk("pause_start_door_open", int'(bus.state_out), 3);
      bus.door_closed = 1'b1;
      tick();
      chk("pause_door_shut", int'(bus.state_out), 3);
      bus.start = 1'b1;
      tick();
      chk("resume_cook", int'(bus.state_out), 2);
      bus.start = 1'b0;
      tick();

      // timer_done and stop together: timer_done wins
      bus.timer_done = 1'b1; bus.stop = 1'b1;
      tick();
      chk("done_priority", int'(bus.state_out), 4);
      chk("done_mag_off", int'(bus.mag_on), 0);
      bus.timer_done = 1'b0; bus.stop = 1'b0;
`ifdef BEEP_EN
      beeps = (beep === 1'b1) ? 1 : 0;
      for (int i = 0; i < 11; i++) begin
         tick();
         if (beep === 1'b1) beeps++;
      end
      chk("beep_cycles", beeps, 8);
`else
      beeps = 0;
      for (int i = 0; i < 11; i++) tick();
`endif
      chk("done_hold", int'(bus.state_out), 4);
      key(4'd12);
      chk("done_ignore_code12", int'(bus.state_out), 4);

      // stop from DONE: IDLE with a one-cycle clear pulse
      bus.stop = 1'b1;
      tick();
      chk("done_stop_idle", int'(bus.state_out), 0);
      chk("done_stop_clearn", int'(bus.timer_clearn), 0);
      chk("idle_count_zero", int'(dut.digit_count), 0);
      bus.stop = 1'b0;
      tick();
      chk("clearn_one_cycle", int'(bus.timer_clearn), 1);

      // stop from ENTRY
      key(4'd5);
      chk("k5_entry", int'(bus.state_out), 1);
      bus.stop = 1'b1;
      tick();
      chk("entry_stop_idle", int'(bus.state_out), 0);
      chk("entry_stop_clearn", int'(bus.timer_clearn), 0);
      bus.stop = 1'b0;
      tick();

      // start with door open in ENTRY is ignored
      key(4'd3);
      bus.door_closed = 1'b0;
      bus.start = 1'b1;
      tick();
      chk("entry_start_door_open", int'(bus.state_out), 1);
      bus.start = 1'b0;
      tick();
      bus.door_closed = 1'b1;
      bus.start = 1'b1;
      tick();
      chk("entry_start_cook", int'(bus.state_out), 2);
      tick();

      // clear mid-COOK returns everything to reset values
      clear = 1'b1;
      tick();
      chk("clr_state", int'(bus.state_out), 0);
      chk("clr_mag", int'(bus.mag_on), 0);
      chk("clr_enable", int'(bus.timer_enable), 0);
      chk("clr_loadn", int'(bus.timer_loadn), 0);
      chk("clr_digit", int'(bus.timer_digit), 0);
      chk("clr_strobe", int'(bus.digit_strobe), 0);
      chk("clr_clearn", int'(bus.timer_clearn), 0);
`ifdef BEEP_EN
      chk("clr_beep", int'(beep), 0);
`endif
      clear = 1'b0;
      bus.start = 1'b0;
      tick();
      chk("clr_clearn_release", int'(bus.timer_clearn), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
